decryption: RTL



---
 rtl/decryption_if.sv | 21 ++
 rtl/decryption.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/decryption_if.sv
// Receive-side AES block bus: ciphertext/key in from the deserializer, plaintext out to the FIFO.
interface decryption_if;
  logic [127:0] ATD_parallel;
  logic         key_received;
  logic [127:0] key;
  logic         data_ready;
  logic         fifo_full;
  logic [127:0] process_out_data;
  logic         data_out_load;
  logic         data_taken;

  modport master (
    output ATD_parallel, key_received, key, data_ready, fifo_full,
    input  process_out_data, data_out_load, data_taken
  );

  modport slave (
    input  ATD_parallel, key_received, key, data_ready, fifo_full,
    output process_out_data, data_out_load, data_taken
  );
endinterface

// File: rtl/decryption.sv
// AES-128 inverse cipher: key expanded once per key_received (one round key per cycle),
// then one inverse round per clock with a FIFO-gated output strobe.
module decryption (
  input  logic        clk,
  input  logic        n_rst,
  decryption_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StKeyExp, StWait, StRound, StFinal, StOut} state_e;

  state_e              state_q;
  logic [10:0][127:0]  rk_q;
  logic [127:0]        s_q, out_q;
  logic [3:0]          cnt_q, cnt_prev;
  logic                key_ready_q, taken_q;
  logic [127:0]        core, mixed, final_v, next_rk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  // InvShiftRows followed by InvSubBytes; byte r+4c sits at [127-8(r+4c) -: 8].
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      t[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return t;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] w, input logic [7:0] rc);
    logic [31:0] tmp, n0, n1, n2, n3;
    tmp = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h0};
    n0  = w[127:96] ^ tmp;
    n1  = w[95:64] ^ n0;
    n2  = w[63:32] ^ n1;
    n3  = w[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    cnt_prev = cnt_q - 4'd1;
    core     = inv_sub_shift(s_q);
    mixed    = inv_mix(core ^ rk_q[cnt_q]);
    final_v  = core ^ rk_q[0];
    next_rk  = key_step(rk_q[cnt_prev], rcon(cnt_q));
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      rk_q        <= '0;
      s_q         <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        StIdle, StKeyExp, StWait: begin
          if (bus_io.key_received) begin
            rk_q[0]     <= bus_io.key;
            key_ready_q <= 1'b0;
            cnt_q       <= 4'd1;
            state_q     <= StKeyExp;
          end else if (state_q == StKeyExp) begin
            rk_q[cnt_q] <= next_rk;
            if (cnt_q == 4'd10) begin
              key_ready_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= StWait;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else if (state_q == StWait && bus_io.data_ready && key_ready_q) begin
            s_q     <= bus_io.ATD_parallel ^ rk_q[10];
            cnt_q   <= 4'd9;
            taken_q <= 1'b1;
            state_q <= StRound;
          end
        end
        StRound: begin
          s_q   <= mixed;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StFinal;
        end
        StFinal: begin
          s_q     <= final_v;
          out_q   <= final_v;
          state_q <= StOut;
        end
        StOut: begin
          if (!bus_io.fifo_full) state_q <= StWait;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The load strobe must react to fifo_full within the OUT cycle itself.
  assign bus_io.data_out_load    = (state_q == StOut) && !bus_io.fifo_full;
  assign bus_io.data_taken       = taken_q;
  assign bus_io.process_out_data = out_q;

endmodule
